// File: rtl/lsu_seq_pkg.sv
// Shared defines for the load/store sequencer: memory size codes, FSM states
// and size-decode helpers used by the top and the load extender.
package lsu_seq_pkg;

  localparam int DEFAULT_XLEN = 64;

  // Size codes towards the data memory; a doubleword store reuses MEM_LD.
  localparam logic [2:0] MEM_LB = 3'd0;
  localparam logic [2:0] MEM_LH = 3'd1;
  localparam logic [2:0] MEM_LW = 3'd2;
  localparam logic [2:0] MEM_LD = 3'd3;
  localparam logic [2:0] MEM_SB = 3'd4;
  localparam logic [2:0] MEM_SH = 3'd5;
  localparam logic [2:0] MEM_SW = 3'd6;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    SPLIT,
    RESP
  } lsu_state_e;

  // log2 of the access size in bytes
  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } size_e;

  function automatic size_e op_size(input logic [2:0] op);
    case (op)
      MEM_LB, MEM_SB: return SZ_B;
      MEM_LH, MEM_SH: return SZ_H;
      MEM_LW, MEM_SW: return SZ_W;
      default:        return SZ_D;
    endcase
  endfunction

  function automatic logic [3:0] size_bytes(input size_e s);
    return 4'd1 << s;
  endfunction

  function automatic logic [2:0] align_mask(input size_e s);
    return 3'(size_bytes(s) - 4'd1);
  endfunction

endpackage

// File: rtl/lsu_load_ext.sv
// Sign-extends the low 1/2/4/8 bytes of a load value to the full datapath width.
module lsu_load_ext
  import lsu_seq_pkg::*;
#(
  parameter int XLEN = DEFAULT_XLEN
) (
  input  logic [XLEN-1:0] data,
  input  size_e           size,
  output logic [XLEN-1:0] result
);

  int unsigned                shamt;
  logic signed [XLEN-1:0]     shifted;

  // Move the sign bit to the MSB, then shift back arithmetically.
  always_comb begin
    shamt   = XLEN - (32'd8 << size);
    shifted = data << shamt;
    result  = shifted >>> shamt;
  end

endmodule

// File: rtl/lsu_seq.sv
// Load/store sequencer: issues aligned accesses in one cycle and either splits
// misaligned ones into byte accesses or rejects them with resp_err.
module lsu_seq
  import lsu_seq_pkg::*;
#(
  parameter int SPLIT_MISALIGNED = 1,
  parameter int XLEN             = DEFAULT_XLEN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [2:0]      req_op,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_rdata,
  output logic            resp_err,
  output logic            mem_read,
  output logic            mem_write,
  output logic [2:0]      mem_op,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic [XLEN-1:0] mem_rdata
);

  localparam bit SPLIT_EN = (SPLIT_MISALIGNED != 0);

  lsu_state_e      state, state_next;
  logic [2:0]      cnt;
  logic            we_q;
  logic [2:0]      op_q;
  logic [XLEN-1:0] addr_q;
  logic [XLEN-1:0] wdata_q;
  logic [XLEN-1:0] data_q;
  logic            err_q;

  size_e           size_req;
  size_e           size_q;
  logic            accept;
  logic            misaligned;
  logic            last_byte;
  logic [XLEN-1:0] split_addr;
  logic [7:0]      store_byte;
  logic [XLEN-1:0] assembled;
  logic [XLEN-1:0] extended;

  assign size_req   = op_size(req_op);
  assign size_q     = op_size(op_q);
  assign misaligned = (req_addr[2:0] & align_mask(size_req)) != 3'd0;
  assign accept     = req_valid && req_ready;
  assign last_byte  = ({1'b0, cnt} == (size_bytes(size_q) - 4'd1));
  assign split_addr = addr_q + XLEN'(cnt);
  assign store_byte = wdata_q[{cnt, 3'b000} +: 8];

  // Load value with the current byte dropped into lane cnt.
  always_comb begin
    assembled                       = data_q;
    assembled[{cnt, 3'b000} +: 8]   = mem_rdata[7:0];
  end

  lsu_load_ext #(
    .XLEN(XLEN)
  ) u_load_ext (
    .data  (assembled),
    .size  (size_q),
    .result(extended)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Strobes and handshakes are masked while rst is high so an aborted
  // transaction produces no further memory traffic or response.
  always_comb begin
    state_next = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_op     = MEM_LB;
    mem_addr   = '0;
    mem_wdata  = '0;
    case (state)
      IDLE: begin
        req_ready = !rst;
        if (req_valid && !rst) begin
          if (!misaligned) begin
            state_next = ACCESS;
          end else if (SPLIT_EN) begin
            state_next = SPLIT;
          end else begin
            state_next = RESP;
          end
        end
      end
      ACCESS: begin
        mem_read   = !we_q && !rst;
        mem_write  = we_q && !rst;
        mem_op     = op_q;
        mem_addr   = addr_q;
        mem_wdata  = wdata_q;
        state_next = RESP;
      end
      SPLIT: begin
        mem_read  = !we_q && !rst;
        mem_write = we_q && !rst;
        mem_op    = we_q ? MEM_SB : MEM_LB;
        mem_addr  = split_addr;
        mem_wdata = XLEN'(store_byte);
        if (last_byte) begin
          state_next = RESP;
        end
      end
      RESP: begin
        resp_valid = !rst;
        if (resp_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Request latch, byte counter and response data.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= 3'd0;
      we_q    <= 1'b0;
      op_q    <= MEM_LB;
      addr_q  <= '0;
      wdata_q <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            we_q    <= req_we;
            op_q    <= req_op;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            data_q  <= '0;
            cnt     <= 3'd0;
            err_q   <= misaligned && !SPLIT_EN;
          end
        end
        ACCESS: begin
          if (!we_q) begin
            data_q <= mem_rdata;
          end
        end
        SPLIT: begin
          cnt <= cnt + 3'd1;
          if (!we_q) begin
            data_q <= last_byte ? extended : assembled;
          end
        end
        RESP: begin
          if (resp_ready) begin
            err_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign resp_rdata = data_q;
  assign resp_err   = err_q;

endmodule

// File: tb/tb_lsu_seq.sv
// Self-checking bench for lsu_seq: directed scenarios plus randomized loads and
// stores against a byte-array memory and a size/alignment reference model.
module tb_lsu_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_op = 3'd0;
  logic [63:0] req_addr = '0;
  logic [63:0] req_wdata = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic [63:0] resp_rdata;
  logic        resp_err;
  logic        mem_read, mem_write;
  logic [2:0]  mem_op;
  logic [63:0] mem_addr, mem_wdata, mem_rdata;

  logic        r_req_valid = 1'b0;
  logic        r_req_ready;
  logic        r_resp_valid;
  logic        r_resp_ready = 1'b1;
  logic [63:0] r_resp_rdata;
  logic        r_resp_err;
  logic        r_mem_read, r_mem_write;
  logic [2:0]  r_mem_op;
  logic [63:0] r_mem_addr, r_mem_wdata;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic        we;
    logic [2:0]  op;
    logic [63:0] addr;
    logic [7:0]  b;
  } strobe_t;

  strobe_t     slog[$];
  int          both_err = 0;
  int          r_strobes = 0;
  logic [7:0]  mem_arr [256];
  logic        pk_en = 1'b0;
  logic [7:0]  pk_addr = '0;
  logic [63:0] pk_data = '0;

  always #5 clk = ~clk;

  lsu_seq #(.SPLIT_MISALIGNED(1), .XLEN(64)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_read(mem_read), .mem_write(mem_write), .mem_op(mem_op), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  lsu_seq #(.SPLIT_MISALIGNED(0), .XLEN(64)) dut_rej (
    .clk(clk), .rst(rst),
    .req_valid(r_req_valid), .req_ready(r_req_ready), .req_we(req_we), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(r_resp_valid), .resp_ready(r_resp_ready), .resp_rdata(r_resp_rdata), .resp_err(r_resp_err),
    .mem_read(r_mem_read), .mem_write(r_mem_write), .mem_op(r_mem_op), .mem_addr(r_mem_addr),
    .mem_wdata(r_mem_wdata), .mem_rdata(64'd0)
  );

  function automatic int nb(input logic [2:0] op);
    case (op)
      3'd0, 3'd4: return 1;
      3'd1, 3'd5: return 2;
      3'd2, 3'd6: return 4;
      default:    return 8;
    endcase
  endfunction

  function automatic logic [63:0] ref_load(input logic [63:0] addr, input int n);
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < n; i++) v[8*i +: 8] = mem_arr[8'(addr + 64'(i))];
    if (v[8*n-1]) v = v | (~64'd0 << (8*n));
    return v;
  endfunction

  // Memory answers any size code with the addressed bytes, sign-extended.
  always_comb begin
    logic [63:0] v;
    int n;
    v = '0;
    n = nb(mem_op);
    for (int i = 0; i < 8; i++) if (i < n) v[8*i +: 8] = mem_arr[8'(mem_addr + 64'(i))];
    if (v[8*n-1]) v = v | (~64'd0 << (8*n));
    mem_rdata = v;
  end

  always @(posedge clk) begin
    if (pk_en) for (int i = 0; i < 8; i++) mem_arr[8'(pk_addr + 8'(i))] <= pk_data[8*i +: 8];
    if (mem_write) for (int i = 0; i < 8; i++)
      if (i < nb(mem_op)) mem_arr[8'(mem_addr + 64'(i))] <= mem_wdata[8*i +: 8];
    if (mem_read || mem_write)
      slog.push_back('{we: mem_write, op: mem_op, addr: mem_addr,
                       b: (mem_write ? mem_wdata[7:0] : mem_rdata[7:0])});
    if (mem_read && mem_write) both_err <= both_err + 1;
    if (r_mem_read || r_mem_write) r_strobes <= r_strobes + 1;
  end

  task automatic poke(input logic [7:0] a, input logic [63:0] d);
    pk_en = 1'b1; pk_addr = a; pk_data = d;
    @(posedge clk); #1;
    pk_en = 1'b0;
  endtask

  task automatic run_txn(input logic we, input logic [2:0] op, input logic [63:0] addr,
                         input logic [63:0] wdata, output logic [63:0] rdata,
                         output logic err, output int lat);
    slog.delete();
    req_we = we; req_op = op; req_addr = addr; req_wdata = wdata;
    req_valid = 1'b1; resp_ready = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    rdata = resp_rdata;
    err   = resp_err;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_resp_valid got=%b exp=0", resp_valid); end
    checks++; if ({mem_read, mem_write} !== 2'b00) begin errors++; $display("[TB] FAIL reset_strobes got=%b exp=00", {mem_read, mem_write}); end
    checks++; if (resp_err !== 1'b0 || resp_rdata !== 64'd0) begin errors++; $display("[TB] FAIL reset_resp got err=%b data=%h exp 0/0", resp_err, resp_rdata); end
    rst = 1'b0;
    #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_req_ready got=%b exp=1", req_ready); end
  endtask

  task automatic test_aligned_load();
    logic [63:0] rd; logic er; int lat;
    poke(8'h10, 64'h8877665544332211);
    run_txn(1'b0, 3'd3, 64'h10, 64'd0, rd, er, lat);
    checks++; if (rd !== 64'h8877665544332211) begin errors++; $display("[TB] FAIL ld_data got=%h exp=8877665544332211", rd); end
    checks++; if (lat !== 2) begin errors++; $display("[TB] FAIL ld_latency got=%0d exp=2", lat); end
    checks++; if (slog.size() !== 1) begin errors++; $display("[TB] FAIL ld_strobes got=%0d exp=1", slog.size()); end
  endtask

  task automatic test_misaligned_store();
    logic [63:0] rd; logic er; int lat;
    logic [31:0] wd;
    wd = 32'hDEADBEEF;
    run_txn(1'b1, 3'd6, 64'h23, 64'hDEADBEEF, rd, er, lat);
    checks++; if (lat !== 5) begin errors++; $display("[TB] FAIL sw_split_latency got=%0d exp=5", lat); end
    checks++; if (slog.size() !== 4) begin errors++; $display("[TB] FAIL sw_split_strobes got=%0d exp=4", slog.size()); end
    for (int k = 0; k < 4; k++) begin
      if (k < slog.size()) begin
        checks++;
        if (slog[k].we !== 1'b1 || slog[k].op !== 3'd4 || slog[k].addr !== 64'h23 + 64'(k) || slog[k].b !== wd[8*k +: 8]) begin
          errors++;
          $display("[TB] FAIL sw_split_byte%0d got we=%b op=%0d addr=%h b=%h exp we=1 op=4 addr=%h b=%h",
                   k, slog[k].we, slog[k].op, slog[k].addr, slog[k].b, 64'h23 + 64'(k), wd[8*k +: 8]);
        end
      end
    end
    checks++; if (rd !== 64'd0 || er !== 1'b0) begin errors++; $display("[TB] FAIL sw_split_resp got data=%h err=%b exp 0/0", rd, er); end
  endtask

  task automatic test_misaligned_load();
    logic [63:0] rd; logic er; int lat;
    poke(8'h40, 64'h0000000000923400);
    run_txn(1'b0, 3'd1, 64'h41, 64'd0, rd, er, lat);
    checks++; if (rd !== 64'hFFFFFFFFFFFF9234) begin errors++; $display("[TB] FAIL lh_split_data got=%h exp=ffffffffffff9234", rd); end
    checks++; if (lat !== 3) begin errors++; $display("[TB] FAIL lh_split_latency got=%0d exp=3", lat); end
    checks++;
    if (slog.size() !== 2 || slog[0].op !== 3'd0 || slog[1].op !== 3'd0 || slog[0].we !== 1'b0 || slog[1].addr !== 64'h42) begin
      errors++;
      $display("[TB] FAIL lh_split_reads got n=%0d exp two LB reads at 41,42", slog.size());
    end
  endtask

  task automatic test_reject();
    int lat;
    req_we = 1'b0; req_op = 3'd2; req_addr = 64'h02; req_wdata = '0;
    r_req_valid = 1'b1; r_resp_ready = 1'b1;
    @(posedge clk); #1;
    r_req_valid = 1'b0;
    lat = 1;
    while (!r_resp_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    checks++; if (lat !== 1) begin errors++; $display("[TB] FAIL reject_latency got=%0d exp=1", lat); end
    checks++; if (r_resp_err !== 1'b1 || r_resp_rdata !== 64'd0) begin errors++; $display("[TB] FAIL reject_resp got err=%b data=%h exp 1/0", r_resp_err, r_resp_rdata); end
    @(posedge clk); #1;
    checks++; if (r_strobes !== 0) begin errors++; $display("[TB] FAIL reject_strobes got=%0d exp=0", r_strobes); end
    checks++; if (r_req_ready !== 1'b1 || r_resp_valid !== 1'b0) begin errors++; $display("[TB] FAIL reject_return got ready=%b valid=%b exp 1/0", r_req_ready, r_resp_valid); end
  endtask

  task automatic test_backpressure();
    logic [63:0] exp; int lat;
    exp = ref_load(64'h48, 4);
    slog.delete();
    req_we = 1'b0; req_op = 3'd2; req_addr = 64'h48; req_valid = 1'b1; resp_ready = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (resp_valid !== 1'b1 || resp_rdata !== exp || req_ready !== 1'b0) begin
        errors++;
        $display("[TB] FAIL hold_cycle%0d got valid=%b data=%h ready=%b exp 1/%h/0", k, resp_valid, resp_rdata, req_ready, exp);
      end
      @(posedge clk); #1;
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin errors++; $display("[TB] FAIL hold_release got ready=%b valid=%b exp 1/0", req_ready, resp_valid); end
  endtask

  task automatic test_reset_abort();
    logic seen;
    seen = 1'b0;
    slog.delete();
    req_we = 1'b1; req_op = 3'd3; req_addr = 64'h31; req_wdata = 64'h1122334455667788;
    req_valid = 1'b1; resp_ready = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("[TB] FAIL abort_ready got=%b exp=1", req_ready); end
    repeat (10) begin
      if (resp_valid) seen = 1'b1;
      @(posedge clk); #1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("[TB] FAIL abort_resp got valid seen=%b exp=0", seen); end
    checks++;
    if (slog.size() !== 2 || slog[0].b !== 8'h88 || slog[1].b !== 8'h77 || slog[1].addr !== 64'h32) begin
      errors++;
      $display("[TB] FAIL abort_writes got n=%0d exp 2 bytes 88,77", slog.size());
    end
  endtask

  task automatic test_wrap();
    logic [63:0] rd, exp, a; logic er; int lat;
    a = 64'hFFFF_FFFF_FFFF_FFFE;
    exp = ref_load(a, 4);
    run_txn(1'b0, 3'd2, a, 64'd0, rd, er, lat);
    checks++; if (rd !== exp) begin errors++; $display("[TB] FAIL wrap_data got=%h exp=%h", rd, exp); end
    checks++;
    if (slog.size() !== 4 || slog[2].addr !== 64'd0 || slog[3].addr !== 64'd1 || slog[1].addr !== 64'hFFFF_FFFF_FFFF_FFFF) begin
      errors++;
      $display("[TB] FAIL wrap_addr got n=%0d a2=%h exp addrs ..fe,..ff,0,1", slog.size(), slog.size() > 2 ? slog[2].addr : 64'hx);
    end
  endtask

  task automatic test_random();
    logic [63:0] rd, exp, a, wd, got; logic er, we; logic [2:0] op; int lat, n, exp_lat, exp_str;
    for (int t = 0; t < 40; t++) begin
      we = 1'($urandom_range(0, 1));
      op = 3'($urandom_range(0, 3));
      if (we && op != 3'd3) op = op + 3'd4;
      a  = {32'($urandom), 32'($urandom)};
      wd = {32'($urandom), 32'($urandom)};
      n  = nb(op);
      exp_lat = ((a % 64'(n)) == 0) ? 2 : n + 1;
      exp_str = ((a % 64'(n)) == 0) ? 1 : n;
      exp = we ? 64'd0 : ref_load(a, n);
      run_txn(we, op, a, wd, rd, er, lat);
      checks++;
      if (rd !== exp || er !== 1'b0 || lat !== exp_lat || slog.size() !== exp_str) begin
        errors++;
        $display("[TB] FAIL rand%0d we=%b op=%0d addr=%h got data=%h lat=%0d n=%0d exp data=%h lat=%0d n=%0d",
                 t, we, op, a, rd, lat, slog.size(), exp, exp_lat, exp_str);
      end
      if (we) begin
        got = ref_load(a, n);
        wd  = (n == 8) ? wd : (wd & ~(~64'd0 << (8*n)));
        if (wd[8*n-1]) wd = wd | (~64'd0 << (8*n));
        checks++; if (got !== wd) begin errors++; $display("[TB] FAIL rand%0d_mem got=%h exp=%h", t, got, wd); end
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 32; i++) poke(8'(i * 8), {32'($urandom), 32'($urandom)});
    test_reset();
    test_aligned_load();
    test_misaligned_store();
    test_misaligned_load();
    test_reject();
    test_backpressure();
    test_reset_abort();
    test_wrap();
    test_random();
    checks++; if (both_err !== 0) begin errors++; $display("[TB] FAIL both_strobes got=%0d exp=0", both_err); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
